// File: rtl/t_vpi_scope_pkg.sv
// Shared types and default sizing for the generate-scope sampler and its capture FIFO.
package t_vpi_scope_pkg;

  localparam int LANES_DEF = 2;
  localparam int DEPTH_DEF = 4;
  localparam int CNT_W_DEF = 8;

  localparam int ENTRY_DATA_W  = LANES_DEF;
  localparam int ENTRY_STAMP_W = CNT_W_DEF;

  typedef struct packed {
    logic [ENTRY_DATA_W-1:0]  data;
    logic [ENTRY_STAMP_W-1:0] stamp;
  } entry_t;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/t_vpi_scope_fifo.sv
// First-word fall-through FIFO with a registered head; the head keeps its last
// value while empty, and a push into a full FIFO is accepted when a pop frees a slot.
module t_vpi_scope_fifo
  import t_vpi_scope_pkg::*;
#(
  parameter int  DEPTH = DEPTH_DEF,
  parameter type item_t = entry_t,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             push,
  input  item_t            din,
  input  logic             pop,
  output item_t            dout,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  item_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_next;
  logic [LVL_W-1:0] level_next;
  logic             do_push;
  logic             do_pop;

  assign empty      = (level == '0);
  assign full       = (level == LVL_W'(DEPTH));
  assign do_pop     = pop && !empty;
  assign do_push    = push && (!full || do_pop);
  assign rd_next    = rd_ptr + PTR_W'(do_pop);
  assign level_next = level + LVL_W'(do_push) - LVL_W'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_next;
      level  <= level_next;
      // When the entry being written becomes the new head, take it straight from din.
      if (level_next != '0)
        dout <= (do_push && (wr_ptr == rd_next)) ? din : mem[rd_next];
    end
  end

endmodule

// File: rtl/t_vpi_scope_sampler.sv
// Samples per-lane levels, counts toggles per lane inside lane[i] scopes and
// queues timestamped change snapshots for a valid/ready monitor drain.
//
// state | meaning
// PRIME | first sample only seeds in_q; no change detection, no push
// RUN   | each sample is compared with in_q; changes are counted and pushed
module t_vpi_scope_sampler
  import t_vpi_scope_pkg::*;
#(
  parameter int  LANES = LANES_DEF,
  parameter int  DEPTH = DEPTH_DEF,
  parameter int  CNT_W = CNT_W_DEF,
  localparam int SEL_W = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic [LANES-1:0] in_vec,
  input  logic             sample_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LANES-1:0] out_data,
  output logic [CNT_W-1:0] out_stamp,
  output logic [LVL_W-1:0] level,
  output logic             overflow,
  input  logic [SEL_W-1:0] cnt_sel,
  output logic [CNT_W-1:0] cnt_out
);

  typedef struct packed {
    logic [LANES-1:0] data;
    logic [CNT_W-1:0] stamp;
  } slot_t;

  state_t           state;
  logic [LANES-1:0] in_q;
  logic [LANES-1:0] chg;
  logic [CNT_W-1:0] stamp;
  logic             run_sample;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  slot_t            push_entry;
  slot_t            head;
  logic [CNT_W-1:0] cnt_all [LANES];

  assign chg        = in_vec ^ in_q;
  assign run_sample = sample_en && (state == RUN);
  assign push       = run_sample && (|chg);
  assign pop        = out_valid && out_ready;
  assign push_entry = '{data: in_vec, stamp: stamp};

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state    <= PRIME;
      in_q     <= '0;
      stamp    <= '0;
      overflow <= 1'b0;
    end else begin
      stamp <= stamp + CNT_W'(1);
      if (sample_en) in_q <= in_vec;
      case (state)
        PRIME:   if (sample_en) state <= RUN;
        RUN:     state <= RUN;
        default: state <= PRIME;
      endcase
      // Only a push that no pop can make room for is lost.
      if (push && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : lane
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l)
        cnt <= '0;
      else if (run_sample && chg[i] && (cnt != '1))
        cnt <= cnt + CNT_W'(1);
    end

    assign cnt_all[i] = cnt;
  end

  always_comb begin
    cnt_out = '0;
    for (int i = 0; i < LANES; i++)
      if (cnt_sel == SEL_W'(i)) cnt_out = cnt_all[i];
  end

  t_vpi_scope_fifo #(
    .DEPTH  (DEPTH),
    .item_t (slot_t)
  ) u_fifo (
    .clk     (clk),
    .reset_l (reset_l),
    .push    (push),
    .din     (push_entry),
    .pop     (out_ready),
    .dout    (head),
    .level   (level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = head.data;
  assign out_stamp = head.stamp;

endmodule
